dac_sample_sequencer: RTL and testbench

DAC_SAMPLE_SEQUENCER -- requirements
Module: dac_sample_sequencer

---
 rtl/dac_sample_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer
//   Steps a frame of NUM_CHANNELS channel slots through the DAC main_state
//   phase codes, fetches one amplifier sample per slot via a req/ack
//   handshake and counts frames in timestamp.
//
// Ports
//   dataclk        in   sole clock, rising edge
//   reset          in   synchronous, active-low
//   run            in   level; start from IDLE, request stop when low
//   continuous_run in   ignore max_timestep when high
//   max_timestep   in   [31:0] frame count at which a bounded run stops
//   phase_cycles   in   [3:0] dwell cycles per phase (0 acts as 1)
//   sample_ack     in   upstream accepts sample_req, sample_data valid
//   sample_data    in   [15:0] amplifier word for current channel
//   main_state     out  [31:0] phase code
//   channel        out  [5:0] current channel slot
//   DAC_input      out  [15:0] last accepted sample
//   sample_req     out  sample request for current slot
//   sample_clk     out  high in phases 100/135/170 of channel 0
//   timestamp      out  [31:0] completed frame count
//   underflow      out  sticky: a slot ended its window without ack
//   running        out  high in RUN and DRAIN
module dac_sample_sequencer #(
  parameter int unsigned NUM_CHANNELS = 20
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        run,
  input  logic        continuous_run,
  input  logic [31:0] max_timestep,
  input  logic [3:0]  phase_cycles,
  input  logic        sample_ack,
  input  logic [15:0] sample_data,
  output logic [31:0] main_state,
  output logic [5:0]  channel,
  output logic [15:0] DAC_input,
  output logic        sample_req,
  output logic        sample_clk,
  output logic [31:0] timestamp,
  output logic        underflow,
  output logic        running
);

  localparam int unsigned CH_W  = 6;
  localparam int unsigned PH_W  = 3;
  localparam int unsigned DW_W  = 4;

  localparam logic [31:0] MS_WAIT     = 32'd99;
  localparam logic [31:0] MS_CLK1_A   = 32'd100;
  localparam logic [31:0] MS_CLK9_D   = 32'd135;
  localparam logic [31:0] MS_CLK18_C  = 32'd170;
  localparam logic [31:0] MS_CLK27_B  = 32'd205;

  localparam logic [PH_W-1:0] PH_WAIT = 3'd0;
  localparam logic [PH_W-1:0] PH_CLK1 = 3'd1;
  localparam logic [PH_W-1:0] PH_CLK9 = 3'd2;
  localparam logic [PH_W-1:0] PH_C18  = 3'd3;
  localparam logic [PH_W-1:0] PH_LAST = 3'd4;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase_idx;
  logic [DW_W-1:0]   dwell;
  logic [DW_W-1:0]   pc_lat;

  logic              dwell_last_c;
  logic              slot_last_c;
  logic              frame_last_c;
  logic [31:0]       ts_inc_c;
  logic              stop_c;
  logic [PH_W-1:0]   nxt_phase_c;
  logic [CH_W-1:0]   nxt_channel_c;
  logic              nxt_sclk_c;

  // Phase index to main_state code
  function automatic logic [31:0] phase_code(input logic [PH_W-1:0] p);
    case (p)
      PH_WAIT: phase_code = MS_WAIT;
      PH_CLK1: phase_code = MS_CLK1_A;
      PH_CLK9: phase_code = MS_CLK9_D;
      PH_C18:  phase_code = MS_CLK18_C;
      default: phase_code = MS_CLK27_B;
    endcase
  endfunction

  // Position bookkeeping: where the sequencer goes on the next edge
  always_comb begin
    dwell_last_c  = (dwell == (pc_lat - 4'd1));
    slot_last_c   = dwell_last_c && (phase_idx == PH_LAST);
    frame_last_c  = slot_last_c && (channel == CH_LAST);
    ts_inc_c      = timestamp + 32'd1;
    stop_c        = !continuous_run && (ts_inc_c >= max_timestep);
    nxt_phase_c   = phase_idx;
    nxt_channel_c = channel;
    if (dwell_last_c) begin
      nxt_phase_c = (phase_idx == PH_LAST) ? PH_WAIT : PH_W'(phase_idx + 3'd1);
    end
    if (slot_last_c) begin
      nxt_channel_c = (channel == CH_LAST) ? '0 : CH_W'(channel + 6'd1);
    end
    nxt_sclk_c = (nxt_channel_c == '0) &&
                 ((nxt_phase_c == PH_CLK1) || (nxt_phase_c == PH_CLK9) ||
                  (nxt_phase_c == PH_C18));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      phase_idx  <= PH_WAIT;
      dwell      <= '0;
      pc_lat     <= 4'd1;
      main_state <= MS_WAIT;
      channel    <= '0;
      DAC_input  <= '0;
      sample_req <= 1'b0;
      sample_clk <= 1'b0;
      timestamp  <= '0;
      underflow  <= 1'b0;
      running    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          phase_idx  <= PH_WAIT;
          dwell      <= '0;
          main_state <= MS_WAIT;
          channel    <= '0;
          sample_req <= 1'b0;
          sample_clk <= 1'b0;
          running    <= 1'b0;
          if (run) begin
            state     <= ST_RUN;
            running   <= 1'b1;
            pc_lat    <= (phase_cycles == 4'd0) ? 4'd1 : phase_cycles;
            timestamp <= '0;
            underflow <= 1'b0;
          end
        end

        default: begin
          dwell      <= dwell_last_c ? '0 : DW_W'(dwell + 4'd1);
          phase_idx  <= nxt_phase_c;
          channel    <= nxt_channel_c;
          main_state <= phase_code(nxt_phase_c);
          sample_clk <= nxt_sclk_c;

          // Handshake: accept, time out at end of phase 170, or open at phase 100
          if (sample_req && sample_ack) begin
            DAC_input  <= sample_data;
            sample_req <= 1'b0;
          end else if (sample_req && (phase_idx == PH_C18) && dwell_last_c) begin
            sample_req <= 1'b0;
            underflow  <= 1'b1;
          end else if ((phase_idx == PH_WAIT) && dwell_last_c) begin
            sample_req <= 1'b1;
          end

          // A stop is only honoured on a frame boundary
          if (frame_last_c) begin
            timestamp <= ts_inc_c;
            if ((state == ST_DRAIN) || !run || stop_c) begin
              state      <= ST_IDLE;
              running    <= 1'b0;
              main_state <= MS_WAIT;
              channel    <= '0;
              sample_req <= 1'b0;
              sample_clk <= 1'b0;
            end
          end else if ((state == ST_RUN) && !run) begin
            state <= ST_DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Self-checking bench for dac_sample_sequencer: table-driven bounded runs,
// a DAC_input scoreboard fed by accepted handshakes, and hand sequences
// for underflow, drain/restart, phase_cycles latching and mid-slot reset.
module tb_dac_sample_sequencer;

  logic        dataclk;
  logic        reset;
  logic        run;
  logic        continuous_run;
  logic [31:0] max_timestep;
  logic [3:0]  phase_cycles;
  logic        sample_ack;
  logic [15:0] sample_data;
  logic [31:0] main_state;
  logic [5:0]  channel;
  logic [15:0] DAC_input;
  logic        sample_req;
  logic        sample_clk;
  logic [31:0] timestamp;
  logic        underflow;
  logic        running;

  int checks   = 0;
  int failures = 0;

  logic [15:0] base;
  logic        ack_en;
  logic [5:0]  blk_ch;
  logic [15:0] sb_q[$];
  int          codes[5] = '{99, 100, 135, 170, 205};

  typedef struct {
    logic [3:0]  pc;
    logic [31:0] max_ts;
    int          exp_cycles;
    logic [31:0] exp_ts;
    int          eff_pc;
    logic [15:0] data_base;
  } vec_t;

  vec_t vecs[5];

  dac_sample_sequencer #(.NUM_CHANNELS(20)) dut (
    .dataclk       (dataclk),
    .reset         (reset),
    .run           (run),
    .continuous_run(continuous_run),
    .max_timestep  (max_timestep),
    .phase_cycles  (phase_cycles),
    .sample_ack    (sample_ack),
    .sample_data   (sample_data),
    .main_state    (main_state),
    .channel       (channel),
    .DAC_input     (DAC_input),
    .sample_req    (sample_req),
    .sample_clk    (sample_clk),
    .timestamp     (timestamp),
    .underflow     (underflow),
    .running       (running)
  );

  initial begin
    dataclk = 1'b0;
    forever #5 dataclk = ~dataclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Upstream responder: acks in the same cycle as the request unless blocked
  always @(negedge dataclk) begin
    sample_ack  = ack_en && sample_req && (channel != blk_ch);
    sample_data = base + 16'(channel);
  end

  // Scoreboard: push on accepted handshake, compare one cycle later
  always @(posedge dataclk) begin
    if (reset && sample_req && sample_ack) sb_q.push_back(sample_data);
  end

  always @(negedge dataclk) begin
    logic [15:0] exp_d;
    if (sb_q.size() > 0) begin
      exp_d = sb_q.pop_front();
      chk("dac_input", 32'(DAC_input), 32'(exp_d));
    end
  end

  task automatic check_reset_vals();
    chk("rst_main_state", main_state, 32'd99);
    chk("rst_channel",    32'(channel), 32'd0);
    chk("rst_dac_input",  32'(DAC_input), 32'd0);
    chk("rst_timestamp",  timestamp, 32'd0);
    chk("rst_sample_req", 32'(sample_req), 32'd0);
    chk("rst_sample_clk", 32'(sample_clk), 32'd0);
    chk("rst_underflow",  32'(underflow), 32'd0);
    chk("rst_running",    32'(running), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge dataclk);
    reset = 1'b0;
    run   = 1'b0;
    @(negedge dataclk);
    check_reset_vals();
    reset = 1'b1;
  endtask

  // Expected position after k cycles of running with dwell pc
  task automatic check_pos(input int k, input int pc, input bit full);
    int ph;
    int ch;
    ph = (k / pc) % 5;
    ch = (k / (5 * pc)) % 20;
    chk("main_state", main_state, 32'(codes[ph]));
    chk("channel",    32'(channel), 32'(ch));
    chk("sample_clk", 32'(sample_clk), 32'(ch == 0 && ph >= 1 && ph <= 3));
    chk("running",    32'(running), 32'd1);
    if (full) begin
      chk("sample_req", 32'(sample_req), 32'(ph == 1 && (k % pc) == 0));
      chk("underflow",  32'(underflow), 32'd0);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (running && n < bound) begin
      @(negedge dataclk);
      n++;
    end
    chk("idle_reached", 32'(running), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    run            = 1'b0;
    continuous_run = 1'b0;
    max_timestep   = 32'd0;
    phase_cycles   = 4'd1;
    sample_ack     = 1'b0;
    sample_data    = 16'h0;
    base           = 16'h0;
    ack_en         = 1'b1;
    blk_ch         = 6'd63;

    vecs[0] = '{4'd1, 32'd2, 200, 32'd2, 1, 16'h1234};
    vecs[1] = '{4'd0, 32'd1, 100, 32'd1, 1, 16'h2000};
    vecs[2] = '{4'd3, 32'd1, 300, 32'd1, 3, 16'h3000};
    vecs[3] = '{4'd1, 32'd0, 100, 32'd1, 1, 16'h4000};
    vecs[4] = '{4'd2, 32'd3, 600, 32'd3, 2, 16'h5000};

    repeat (2) @(negedge dataclk);
    do_reset();

    // Bounded runs from the table
    for (int v = 0; v < 5; v++) begin
      int cnt;
      bit done;
      do_reset();
      phase_cycles   = vecs[v].pc;
      continuous_run = 1'b0;
      max_timestep   = vecs[v].max_ts;
      base           = vecs[v].data_base;
      run            = 1'b1;
      cnt  = 0;
      done = 1'b0;
      for (int k = 0; k < 5000 && !done; k++) begin
        @(negedge dataclk);
        if (running) begin
          check_pos(k, vecs[v].eff_pc, 1'b1);
          cnt++;
        end else begin
          done = 1'b1;
          run  = 1'b0;
        end
      end
      chk("vec_finished",  32'(done), 32'd1);
      chk("vec_cycles",    32'(cnt), 32'(vecs[v].exp_cycles));
      chk("vec_timestamp", timestamp, vecs[v].exp_ts);
      chk("vec_idle_ms",   main_state, 32'd99);
      chk("vec_idle_ch",   32'(channel), 32'd0);
      chk("vec_idle_req",  32'(sample_req), 32'd0);
    end

    // Underflow: channel 3 never acked
    do_reset();
    phase_cycles   = 4'd1;
    continuous_run = 1'b1;
    base           = 16'h6000;
    blk_ch         = 6'd3;
    run            = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      @(negedge dataclk);
      check_pos(k, 1, 1'b0);
      if (k == 18) chk("uf_before", 32'(underflow), 32'd0);
      if (k == 18) chk("uf_req_pending", 32'(sample_req), 32'd1);
      if (k == 19) begin
        chk("uf_set",     32'(underflow), 32'd1);
        chk("uf_req_off", 32'(sample_req), 32'd0);
        chk("uf_dac_ch2", 32'(DAC_input), 32'h6002);
      end
      if (k == 40) chk("uf_sticky", 32'(underflow), 32'd1);
    end
    run = 1'b0;
    wait_idle(300);
    chk("uf_idle_sticky", 32'(underflow), 32'd1);
    blk_ch = 6'd63;
    run    = 1'b1;
    @(negedge dataclk);
    chk("uf_restart_running", 32'(running), 32'd1);
    chk("uf_restart_clear",   32'(underflow), 32'd0);
    chk("uf_restart_ts",      timestamp, 32'd0);
    run = 1'b0;
    wait_idle(300);

    // Drain from channel 7, run toggled during drain, restart after IDLE
    do_reset();
    phase_cycles   = 4'd1;
    continuous_run = 1'b1;
    base           = 16'h7000;
    run            = 1'b1;
    for (int k = 0; k <= 101; k++) begin
      @(negedge dataclk);
      if (k <= 99) check_pos(k, 1, 1'b1);
      if (k == 35) run = 1'b0;
      if (k == 40) run = 1'b1;
      if (k == 100) begin
        chk("drain_idle_running", 32'(running), 32'd0);
        chk("drain_idle_ms",      main_state, 32'd99);
        chk("drain_idle_ch",      32'(channel), 32'd0);
        chk("drain_idle_ts",      timestamp, 32'd1);
      end
      if (k == 101) begin
        chk("rerun_running", 32'(running), 32'd1);
        chk("rerun_ts",      timestamp, 32'd0);
        chk("rerun_ms",      main_state, 32'd99);
        chk("rerun_ch",      32'(channel), 32'd0);
      end
    end
    run = 1'b0;
    wait_idle(300);

    // phase_cycles latched at start; change mid-run ignored
    do_reset();
    phase_cycles   = 4'd3;
    continuous_run = 1'b1;
    base           = 16'h8000;
    run            = 1'b1;
    for (int k = 0; k < 180; k++) begin
      @(negedge dataclk);
      if (k == 10) phase_cycles = 4'd7;
      check_pos(k, 3, 1'b1);
    end
    run = 1'b0;
    wait_idle(400);

    // Reset mid-slot at channel 5 of the second frame
    do_reset();
    phase_cycles   = 4'd1;
    continuous_run = 1'b1;
    base           = 16'h9000;
    run            = 1'b1;
    for (int k = 0; k <= 126; k++) begin
      @(negedge dataclk);
      check_pos(k, 1, 1'b1);
    end
    chk("pre_reset_ts",  timestamp, 32'd1);
    chk("pre_reset_dac", 32'(DAC_input) != 32'd0, 32'd1);
    reset = 1'b0;
    @(negedge dataclk);
    check_reset_vals();
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge dataclk);
    chk("post_reset_idle", 32'(running), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
